// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch vs. data port) in front of one shared
// single-port memory. It has fetch anti-starvation, a bounded wait and a sticky timeout flag.
module mem_arbiter #(
    parameter int TIMEOUT     = 255,
    parameter int MAX_IF_WAIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        if_req_i,
    input  logic [63:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [63:0] d_addr_i,
    input  logic [63:0] d_wdata_i,
    output logic        d_ack_o,
    output logic [63:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [63:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        stall_if_o,
    output logic        stall_d_o,
    output logic        err_o
);

    // state  | meaning
    // IDLE   | no access in flight, arbitrate pending requests
    // BUSY_I | fetch access presented to memory
    // BUSY_D | data access presented to memory
    // RESP   | one-cycle ack to the owner, then back to IDLE
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [2:0]    STARVE_MAX = 3'(MAX_IF_WAIT);
    localparam logic [63:0]   ADDR_MASK  = ~64'h7;

    state_t        state_q, state_d;
    logic          owner_d_q, owner_d_d;
    logic [63:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [2:0]    starve_q, starve_d;
    logic          err_q, err_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [63:0]   d_rdata_q, d_rdata_d;
    logic          grant_fetch;
    logic          done;
    logic [63:0]   rsp_data;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            owner_d_q  <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wait_q     <= '0;
            starve_q   <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_d_q  <= owner_d_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            starve_q   <= starve_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d_d   = owner_d_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        starve_d    = starve_q;
        err_d       = err_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_fetch = 1'b0;
        done        = 1'b0;
        rsp_data    = mem_ready_i ? mem_rdata_i : 64'h0;

        case (state_q)
            IDLE: begin
                if (if_req_i || d_req_i) begin
                    grant_fetch = if_req_i && (!d_req_i || starve_q == STARVE_MAX);
                    wait_d      = '0;
                    if (grant_fetch) begin
                        owner_d_d = 1'b0;
                        addr_d    = if_addr_i;
                        we_d      = 1'b0;
                        wdata_d   = '0;
                        starve_d  = '0;
                        state_d   = BUSY_I;
                    end else begin
                        owner_d_d = 1'b1;
                        addr_d    = d_addr_i;
                        we_d      = d_we_i;
                        wdata_d   = d_wdata_i;
                        if (if_req_i && starve_q < STARVE_MAX) begin
                            starve_d = starve_q + 3'd1;
                        end
                        state_d   = BUSY_D;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                // A timed-out access completes normally but with zero data.
                if (mem_ready_i) begin
                    done = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    done  = 1'b1;
                    err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
                if (done) begin
                    wait_d  = '0;
                    state_d = RESP;
                    if (state_q == BUSY_I) begin
                        if_rdata_d = addr_q[2] ? rsp_data[63:32] : rsp_data[31:0];
                    end else if (!we_q) begin
                        d_rdata_d = rsp_data;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req_o   = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign mem_we_o    = (state_q == BUSY_D) && we_q;
    assign mem_addr_o  = mem_req_o ? (addr_q & ADDR_MASK) : 64'h0;
    assign mem_wdata_o = (state_q == BUSY_D) ? wdata_q : 64'h0;
    assign if_ack_o    = (state_q == RESP) && !owner_d_q;
    assign d_ack_o     = (state_q == RESP) && owner_d_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign stall_if_o  = if_req_i && !if_ack_o;
    assign stall_d_o   = d_req_i && !d_ack_o;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/load/store paths, arbitration order,
// timeout, reset mid-access and the ack/mem_req invariants.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        if_req_i;
    logic [63:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [63:0] d_addr_i;
    logic [63:0] d_wdata_i;
    logic        d_ack_o;
    logic [63:0] d_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [63:0] mem_rdata_i;
    logic        mem_ready_i;
    logic        stall_if_o;
    logic        stall_d_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_viol  = 0;
    bit mon_en  = 1'b0;

    mem_arbiter dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_ack_o    (if_ack_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_ack_o     (d_ack_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i),
        .stall_if_o  (stall_if_o),
        .stall_d_o   (stall_d_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Both acks together, or a request issued during an ack cycle, is illegal.
    always @(negedge clk_i) begin
        if (mon_en && ((if_ack_o && d_ack_o) || (mem_req_o && (if_ack_o || d_ack_o)))) begin
            n_viol++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    initial begin
        int cycles;
        int n;
        bit grants [10];

        reset_i     = 1'b1;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        d_req_i     = 1'b0;
        d_we_i      = 1'b0;
        d_addr_i    = '0;
        d_wdata_i   = '0;
        mem_rdata_i = '0;
        mem_ready_i = 1'b0;
        step();
        step();
        check("rst_mem_req", 64'(mem_req_o), 64'd0);
        check("rst_acks", 64'({if_ack_o, d_ack_o}), 64'd0);
        check("rst_if_rdata", 64'(if_rdata_o), 64'd0);
        check("rst_d_rdata", d_rdata_o, 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_mem_addr", mem_addr_o, 64'd0);
        reset_i = 1'b0;
        mon_en  = 1'b1;
        step();

        // Fetch at 0x14, ready the first BUSY cycle: ack two cycles after request.
        if_req_i  = 1'b1;
        if_addr_i = 64'h14;
        step();
        check("f1_mem_req", 64'(mem_req_o), 64'd1);
        check("f1_mem_addr", mem_addr_o, 64'h10);
        check("f1_mem_we", 64'(mem_we_o), 64'd0);
        check("f1_stall_if", 64'(stall_if_o), 64'd1);
        mem_ready_i = 1'b1;
        mem_rdata_i = 64'hAABBCCDD_11223344;
        step();
        check("f1_if_ack", 64'(if_ack_o), 64'd1);
        check("f1_d_ack", 64'(d_ack_o), 64'd0);
        check("f1_if_rdata", 64'(if_rdata_o), 64'hAABBCCDD);
        check("f1_stall_if", 64'(stall_if_o), 64'd0);
        if_req_i    = 1'b0;
        mem_ready_i = 1'b0;
        step();
        check("f1_ack_pulse", 64'(if_ack_o), 64'd0);
        check("f1_rdata_hold", 64'(if_rdata_o), 64'hAABBCCDD);

        // Fetch at 0x08 (low word) with memory ready only on the third BUSY cycle.
        if_req_i  = 1'b1;
        if_addr_i = 64'h08;
        step();
        step();
        step();
        check("f2_wait_ack", 64'(if_ack_o), 64'd0);
        check("f2_wait_req", 64'(mem_req_o), 64'd1);
        mem_ready_i = 1'b1;
        mem_rdata_i = 64'h55556666_77778888;
        step();
        check("f2_if_ack", 64'(if_ack_o), 64'd1);
        check("f2_if_rdata", 64'(if_rdata_o), 64'h77778888);
        if_req_i    = 1'b0;
        mem_ready_i = 1'b0;
        step();

        // Load from 0x28.
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 64'h28;
        step();
        check("ld_mem_addr", mem_addr_o, 64'h28);
        check("ld_mem_we", 64'(mem_we_o), 64'd0);
        check("ld_stall_d", 64'(stall_d_o), 64'd1);
        mem_ready_i = 1'b1;
        mem_rdata_i = 64'h12345678_9ABCDEF0;
        step();
        check("ld_d_ack", 64'(d_ack_o), 64'd1);
        check("ld_if_ack", 64'(if_ack_o), 64'd0);
        check("ld_d_rdata", d_rdata_o, 64'h12345678_9ABCDEF0);
        d_req_i     = 1'b0;
        mem_ready_i = 1'b0;
        step();
        check("ld_ack_pulse", 64'(d_ack_o), 64'd0);

        // Store 0xF to 0x30: acked, load data untouched.
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 64'h30;
        d_wdata_i = 64'hF;
        step();
        check("st_mem_we", 64'(mem_we_o), 64'd1);
        check("st_mem_wdata", mem_wdata_o, 64'hF);
        check("st_mem_addr", mem_addr_o, 64'h30);
        mem_ready_i = 1'b1;
        mem_rdata_i = 64'hDEADBEEF_DEADBEEF;
        step();
        check("st_d_ack", 64'(d_ack_o), 64'd1);
        check("st_d_rdata", d_rdata_o, 64'h12345678_9ABCDEF0);
        d_req_i     = 1'b0;
        d_we_i      = 1'b0;
        mem_ready_i = 1'b0;
        step();

        // Both ports requesting continuously: expect D,D,D,D,I repeating.
        if_req_i    = 1'b1;
        if_addr_i   = 64'h100;
        d_req_i     = 1'b1;
        d_addr_i    = 64'h200;
        mem_ready_i = 1'b1;
        mem_rdata_i = 64'h1;
        n = 0;
        cycles = 0;
        while (n < 10 && cycles < 60) begin
            step();
            cycles++;
            if (if_ack_o) begin
                grants[n] = 1'b1;
                n++;
            end else if (d_ack_o) begin
                grants[n] = 1'b0;
                n++;
            end
        end
        if_req_i    = 1'b0;
        d_req_i     = 1'b0;
        mem_ready_i = 1'b0;
        check("arb_grants_seen", 64'(n), 64'd10);
        for (int i = 0; i < n; i++) begin
            check($sformatf("arb_grant%0d", i), 64'(grants[i]), (i % 5 == 4) ? 64'd1 : 64'd0);
        end
        step();

        // Memory never ready: 255 BUSY cycles, then an ack with zero data and sticky err.
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 64'h40;
        step();
        cycles = 1;
        check("to_err_before", 64'(err_o), 64'd0);
        while (!d_ack_o && cycles < 400) begin
            step();
            cycles++;
        end
        check("to_latency", 64'(cycles), 64'd256);
        check("to_d_ack", 64'(d_ack_o), 64'd1);
        check("to_d_rdata", d_rdata_o, 64'd0);
        check("to_err", 64'(err_o), 64'd1);
        d_req_i = 1'b0;
        step();
        check("to_ack_pulse", 64'(d_ack_o), 64'd0);

        if_req_i    = 1'b1;
        if_addr_i   = 64'h0C;
        mem_ready_i = 1'b1;
        mem_rdata_i = 64'h01234567_89ABCDEF;
        step();
        step();
        check("to_good_ack", 64'(if_ack_o), 64'd1);
        check("to_good_rdata", 64'(if_rdata_o), 64'h01234567);
        check("to_err_sticky", 64'(err_o), 64'd1);
        if_req_i    = 1'b0;
        mem_ready_i = 1'b0;
        step();

        // Reset during BUSY_D aborts silently, then the held request is served again.
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 64'h50;
        step();
        check("rb_busy", 64'(mem_req_o), 64'd1);
        reset_i = 1'b1;
        step();
        check("rb_mem_req", 64'(mem_req_o), 64'd0);
        check("rb_d_ack", 64'(d_ack_o), 64'd0);
        check("rb_err", 64'(err_o), 64'd0);
        check("rb_d_rdata", d_rdata_o, 64'd0);
        reset_i = 1'b0;
        step();
        check("rb_regrant", 64'(mem_req_o), 64'd1);
        check("rb_regrant_addr", mem_addr_o, 64'h50);
        mem_ready_i = 1'b1;
        mem_rdata_i = 64'h77;
        step();
        check("rb_d_ack2", 64'(d_ack_o), 64'd1);
        check("rb_d_rdata2", d_rdata_o, 64'h77);
        d_req_i     = 1'b0;
        mem_ready_i = 1'b0;
        step();
        step();

        check("invariant_violations", 64'(n_viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
